buffer_serializer: RTL and testbench

BUFFER_SERIALIZER -- requirements
Module: buffer

---
 rtl/buffer_serializer_if.sv | 17 +
 rtl/buffer_serializer.sv | 88 ++++++++
 tb/tb_buffer_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_serializer_if.sv
// Bus bundle for buffer_serializer: frame request, nibble input and serial output.
// Macro BUFFER_DEBUG_EN adds the flag/cnt observation signals.
interface buffer_serializer_if;
  logic       ena;
  logic [3:0] data_in;
  logic       data_out;
`ifdef BUFFER_DEBUG_EN
  logic       flag;
  logic [5:0] cnt;

  modport master (output ena, data_in, input data_out, flag, cnt);
  modport slave  (input ena, data_in, output data_out, flag, cnt);
`else
  modport master (output ena, data_in, input data_out);
  modport slave  (input ena, data_in, output data_out);
`endif
endinterface

// File: rtl/buffer_serializer.sv
// Captures 16 nibbles into a 64-bit frame, then shifts it out MSB-first one bit per clock.
// Macro BUFFER_DEBUG_EN exposes the SHIFT-state flag and the internal counter.
module buffer_serializer (
  input  logic               clk,
  input  logic               rst_n,
  buffer_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nxt;
  logic [63:0] frame;
  logic [63:0] frame_nxt;
  logic        data_out;
  logic        data_out_nxt;
  logic [5:0]  slot_lo;

  // Low bit of nibble slot cnt: slot 0 occupies [63:60], slot 15 occupies [3:0].
  assign slot_lo = 6'd60 - {cnt[3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      frame    <= '0;
      data_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      frame    <= frame_nxt;
      data_out <= data_out_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    frame_nxt    = frame;
    data_out_nxt = data_out;
    unique case (state)
      IDLE: begin
        data_out_nxt = 1'b0;
        if (bus.ena) begin
          frame_nxt[63:60] = bus.data_in;
          cnt_nxt          = 6'd1;
          state_nxt        = LOAD;
        end
      end
      LOAD: begin
        frame_nxt[slot_lo +: 4] = bus.data_in;
        if (cnt == 6'd15) begin
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      SHIFT: begin
        data_out_nxt = frame[6'd63 - cnt];
        if (cnt == 6'd63) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.data_out = data_out;

`ifdef BUFFER_DEBUG_EN
  assign bus.flag = (state == SHIFT);
  assign bus.cnt  = cnt;
`endif

endmodule

// File: tb/tb_buffer_serializer.sv
// Directed bench for buffer_serializer: reset, single frames, ena robustness, abort and back-to-back.
module tb_buffer_serializer;

  logic clk = 1'b0;
  logic rst_n;

  buffer_serializer_if bus ();

  buffer_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Observations after edge e of a frame (edge 0 is the starting ena edge).
  logic       obs_dout [0:80];
`ifdef BUFFER_DEBUG_EN
  logic       obs_flag [0:80];
  logic [5:0] obs_cnt  [0:80];
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.ena     = 1'b0;
    bus.data_in = 4'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drives one frame from IDLE; ena stays high for the first ena_len edges.
  task automatic play_frame(input logic [63:0] nibs, input int ena_len);
    for (int e = 0; e <= 80; e++) begin
      bus.ena     = (e < ena_len);
      bus.data_in = (e < 16) ? nibs[63-4*e -: 4] : 4'hA;
      step();
      obs_dout[e] = bus.data_out;
`ifdef BUFFER_DEBUG_EN
      obs_flag[e] = bus.flag;
      obs_cnt[e]  = bus.cnt;
`endif
    end
    bus.ena = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.data_in = 4'hF;
    step();
    step();
    vectors++;
    if (bus.data_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dout: got %0b want 0", bus.data_out);
    end
`ifdef BUFFER_DEBUG_EN
    vectors++;
    if (bus.cnt !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d want 0", bus.cnt);
    end
    vectors++;
    if (bus.flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flag: got %0b want 0", bus.flag);
    end
`endif
    rst_n   = 1'b1;
    bus.ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (bus.data_out !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold_%0d: got %0b want 0", k, bus.data_out);
      end
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    play_frame(64'hFFFF_FFFF_FFFF_FFFF, 1);
    vectors++;
    if (obs_dout[15] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pre_shift: got %0b want 0", obs_dout[15]);
    end
    for (int b = 0; b < 64; b++) begin
      vectors++;
      if (obs_dout[16+b] !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bit_%0d: got %0b want 1", b, obs_dout[16+b]);
      end
    end
    vectors++;
    if (obs_dout[80] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: got %0b want 0", obs_dout[80]);
    end
  endtask

  task automatic test_pattern();
    logic [63:0] pat;
    pat = 64'h0124_89AC_DEFF_F000;
    apply_reset();
    play_frame(pat, 1);
    for (int b = 0; b < 64; b++) begin
      vectors++;
      if (obs_dout[16+b] !== pat[63-b]) begin
        miscompares++;
        $display("FAIL pattern_bit_%0d: got %0b want %0b", b, obs_dout[16+b], pat[63-b]);
      end
    end
    vectors++;
    if (obs_dout[80] !== 1'b0) begin
      miscompares++;
      $display("FAIL pattern_after: got %0b want 0", obs_dout[80]);
    end
  endtask

  task automatic test_ena_drop();
    logic [63:0] pat;
    pat = 64'h3C5A_F00F_1E2D_7B96;
    apply_reset();
    play_frame(pat, 3);
    for (int b = 0; b < 64; b++) begin
      vectors++;
      if (obs_dout[16+b] !== pat[63-b]) begin
        miscompares++;
        $display("FAIL ena_drop_bit_%0d: got %0b want %0b", b, obs_dout[16+b], pat[63-b]);
      end
    end
    vectors++;
    if (obs_dout[80] !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_drop_after: got %0b want 0", obs_dout[80]);
    end
  endtask

  task automatic test_abort();
    logic [63:0] pat;
    logic [63:0] pat2;
    pat  = 64'h0124_89AC_DEFF_F000;
    pat2 = 64'h8421_C3A5_0F96_E17B;
    apply_reset();
    for (int e = 0; e <= 25; e++) begin
      bus.ena     = (e == 0);
      bus.data_in = (e < 16) ? pat[63-4*e -: 4] : 4'h5;
      step();
      if (e >= 16) begin
        vectors++;
        if (bus.data_out !== pat[63-(e-16)]) begin
          miscompares++;
          $display("FAIL abort_pre_bit_%0d: got %0b want %0b", e-16, bus.data_out, pat[63-(e-16)]);
        end
      end
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if (bus.data_out !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_dout: got %0b want 0", bus.data_out);
    end
`ifdef BUFFER_DEBUG_EN
    vectors++;
    if (bus.flag !== 1'b0 || bus.cnt !== 6'd0) begin
      miscompares++;
      $display("FAIL abort_dbg: got flag=%0b cnt=%0d want flag=0 cnt=0", bus.flag, bus.cnt);
    end
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      vectors++;
      if (bus.data_out !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet_%0d: got %0b want 0", k, bus.data_out);
      end
    end
    play_frame(pat2, 1);
    for (int b = 0; b < 64; b++) begin
      vectors++;
      if (obs_dout[16+b] !== pat2[63-b]) begin
        miscompares++;
        $display("FAIL abort_next_bit_%0d: got %0b want %0b", b, obs_dout[16+b], pat2[63-b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] f1;
    logic [63:0] f2;
    f1 = 64'hDEAD_BEEF_0123_4567;
    f2 = 64'h89AB_CDEF_FEDC_BA98;
    apply_reset();
    bus.ena = 1'b1;
    for (int e = 0; e < 160; e++) begin
      if (e < 16)
        bus.data_in = f1[63-4*e -: 4];
      else if (e >= 80 && e < 96)
        bus.data_in = f2[63-4*(e-80) -: 4];
      else
        bus.data_in = 4'h6;
      step();
      if (e >= 16 && e < 80) begin
        vectors++;
        if (bus.data_out !== f1[63-(e-16)]) begin
          miscompares++;
          $display("FAIL b2b_f1_bit_%0d: got %0b want %0b", e-16, bus.data_out, f1[63-(e-16)]);
        end
      end else if (e >= 96) begin
        vectors++;
        if (bus.data_out !== f2[63-(e-96)]) begin
          miscompares++;
          $display("FAIL b2b_f2_bit_%0d: got %0b want %0b", e-96, bus.data_out, f2[63-(e-96)]);
        end
      end
    end
    bus.ena = 1'b0;
  endtask

`ifdef BUFFER_DEBUG_EN
  task automatic test_debug();
    int ones;
    apply_reset();
    play_frame(64'h0124_89AC_DEFF_F000, 1);
    ones = 0;
    for (int e = 0; e <= 79; e++) begin
      if (obs_flag[e] === 1'b1) ones++;
      vectors++;
      if (e < 15) begin
        if (obs_flag[e] !== 1'b0 || obs_cnt[e] !== 6'(e + 1)) begin
          miscompares++;
          $display("FAIL dbg_load_%0d: got flag=%0b cnt=%0d want flag=0 cnt=%0d", e, obs_flag[e], obs_cnt[e], e + 1);
        end
      end else if (e < 79) begin
        if (obs_flag[e] !== 1'b1 || obs_cnt[e] !== 6'(e - 15)) begin
          miscompares++;
          $display("FAIL dbg_shift_%0d: got flag=%0b cnt=%0d want flag=1 cnt=%0d", e, obs_flag[e], obs_cnt[e], e - 15);
        end
      end else begin
        if (obs_flag[e] !== 1'b0 || obs_cnt[e] !== 6'd0) begin
          miscompares++;
          $display("FAIL dbg_end: got flag=%0b cnt=%0d want flag=0 cnt=0", obs_flag[e], obs_cnt[e]);
        end
      end
    end
    vectors++;
    if (ones != 64) begin
      miscompares++;
      $display("FAIL dbg_flag_len: got %0d want 64", ones);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    bus.ena     = 1'b0;
    bus.data_in = 4'h0;
    test_reset();
    test_single_frame();
    test_pattern();
    test_ena_drop();
    test_abort();
    test_back_to_back();
`ifdef BUFFER_DEBUG_EN
    test_debug();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
